// File: rtl/face_frame_sequencer_pkg.sv
// Shared definitions for the face frame sequencer.
//   face_t       : face codes understood by the pixel streamer
//   seq_state_t  : sequencer phases (prime the streamer, run, armed for a switch)
//   NUM_FACES    : number of valid face codes; codes at or above this are ignored
//   FRAME_PIXELS : pixels in one streamed frame
//   face_code_ok : true when a 2-bit code names a real face
package face_pkg;

    typedef enum logic [1:0] {
        FACE_HAPPY   = 2'd0,
        FACE_NEUTRAL = 2'd1,
        FACE_ANGRY   = 2'd2
    } face_t;

    typedef enum logic [1:0] {
        SEQ_PRIME = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_ARMED = 2'd2
    } seq_state_t;

    localparam int NUM_FACES    = 3;
    localparam int FRAME_PIXELS = 320 * 240;

    function automatic logic face_code_ok(input logic [1:0] code);
        return int'(code) < NUM_FACES;
    endfunction

endpackage

// File: rtl/face_frame_sequencer_if.sv
// Monitor tap on the streamer -> VGA sink Avalon-ST link.
//   st_valid : streamer output valid
//   st_ready : VGA sink ready
//   st_eop   : streamer endofpacket
// Handshake: a beat transfers on a clk edge where st_valid and st_ready are
// both high; a transferred beat with st_eop high ends the frame. The
// sequencer only observes these signals and never drives ready.
interface face_frame_sequencer_if;

    logic st_valid;
    logic st_ready;
    logic st_eop;

    // master: whoever owns the real link (streamer/sink, or a bench)
    modport master (output st_valid, output st_ready, output st_eop);
    // slave: the sequencer, monitor-only
    modport slave  (input  st_valid, input  st_ready, input  st_eop);

endinterface

// File: rtl/face_frame_sequencer_confirm_filter.sv
// Candidate filter for noisy classifier results.
//   clk, reset_n : clock, synchronous active-low reset
//   req_valid    : classifier result strobe
//   req_face     : classifier face code (codes >= NUM_FACES are dropped)
//   cand_face    : current candidate face
//   confirmed    : candidate seen CONFIRM_COUNT times in a row (registered)
module face_confirm_filter
    import face_pkg::*;
#(
    parameter int DEFAULT_FACE  = 1,
    parameter int CONFIRM_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [1:0] req_face,
    output logic [1:0] cand_face,
    output logic       confirmed
);

    localparam int CW = $clog2(CONFIRM_COUNT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CONFIRM_COUNT);

    logic [CW-1:0] cand_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_face <= 2'(DEFAULT_FACE);
            cand_cnt  <= '0;
        end else if (req_valid && face_code_ok(req_face)) begin
            if (req_face == cand_face) begin
                // Saturate so a long steady run stays confirmed.
                if (cand_cnt != CNT_FULL) begin
                    cand_cnt <= cand_cnt + CW'(1);
                end
            end else begin
                cand_face <= req_face;
                cand_cnt  <= CW'(1);
            end
        end
    end

    assign confirmed = (cand_cnt == CNT_FULL);

endmodule

// File: rtl/face_frame_sequencer.sv
// Drives face_select of the face-image pixel streamer.
// Confirmed classifier results (or operator forces) arm a switch; the switch
// commits only on an end-of-frame handshake so no frame mixes two images.
// A minimum number of shown frames gates non-forced switches. After reset the
// streamer is held in reset for PRIME_CYCLES cycles to prime its BRAM reads.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   req_valid/face : classifier result
//   force_valid/face : operator override (bypasses confirm and hold gate)
//   st             : Avalon-ST monitor tap (slave modport)
//   face_select    : face code to the streamer
//   pixel_reset    : active-high streamer reset
//   pending        : a switch is waiting for end of frame
//   frame_count    : completed frames (wraps)
//   switch_count   : committed switches (wraps)
//   seq_state      : current sequencer state, for observation
module face_frame_sequencer
    import face_pkg::*;
#(
    parameter int DEFAULT_FACE    = 1,
    parameter int CONFIRM_COUNT   = 4,
    parameter int MIN_HOLD_FRAMES = 30,
    parameter int PRIME_CYCLES    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [1:0]              req_face,
    input  logic                    force_valid,
    input  logic [1:0]              force_face,
    face_frame_sequencer_if.slave   st,
    output logic [1:0]              face_select,
    output logic                    pixel_reset,
    output logic                    pending,
    output logic [15:0]             frame_count,
    output logic [7:0]              switch_count,
    output logic [1:0]              seq_state
);

    localparam logic [1:0] ST_PRIME = SEQ_PRIME;
    localparam logic [1:0] ST_RUN   = SEQ_RUN;
    localparam logic [1:0] ST_ARMED = SEQ_ARMED;

    localparam int HW = $clog2(MIN_HOLD_FRAMES + 1);
    localparam int PW = $clog2(PRIME_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_FULL  = HW'(MIN_HOLD_FRAMES);
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES - 1);

    logic [1:0]    state;
    logic [PW-1:0] prime_cnt;
    logic [HW-1:0] hold_frames;
    logic [1:0]    pending_face;
    logic          force_flag;
    logic [1:0]    cand_face;
    logic          confirmed;
    logic          eof;
    logic          force_ok;
    logic          hold_done;

    face_confirm_filter #(
        .DEFAULT_FACE  (DEFAULT_FACE),
        .CONFIRM_COUNT (CONFIRM_COUNT)
    ) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_face  (req_face),
        .cand_face (cand_face),
        .confirmed (confirmed)
    );

    assign eof       = st.st_valid & st.st_ready & st.st_eop;
    // A force to the face already shown would be a no-op switch, so it is not armed.
    assign force_ok  = force_valid & face_code_ok(force_face) & (force_face != face_select);
    assign hold_done = (hold_frames == HOLD_FULL);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_PRIME;
            prime_cnt    <= '0;
            face_select  <= 2'(DEFAULT_FACE);
            pending_face <= 2'(DEFAULT_FACE);
            force_flag   <= 1'b0;
            frame_count  <= '0;
            switch_count <= '0;
            // Start saturated so the very first switch is not held off.
            hold_frames  <= HOLD_FULL;
        end else begin
            // Frame accounting only once the streamer is out of reset.
            if (state != ST_PRIME && eof) begin
                frame_count <= frame_count + 16'd1;
                if (!hold_done) begin
                    hold_frames <= hold_frames + HW'(1);
                end
            end

            case (state)
                ST_PRIME: begin
                    prime_cnt <= prime_cnt + PW'(1);
                    if (prime_cnt == PRIME_LAST) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Force has priority over a same-cycle confirmation.
                    if (force_ok) begin
                        pending_face <= force_face;
                        force_flag   <= 1'b1;
                        state        <= ST_ARMED;
                    end else if (confirmed && cand_face != face_select && hold_done) begin
                        pending_face <= cand_face;
                        state        <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (eof) begin
                        // Commit the registered choice; same-cycle requests are
                        // re-evaluated from RUN afterwards.
                        face_select  <= pending_face;
                        hold_frames  <= '0;
                        switch_count <= switch_count + 8'd1;
                        force_flag   <= 1'b0;
                        state        <= ST_RUN;
                    end else if (force_ok) begin
                        pending_face <= force_face;
                        force_flag   <= 1'b1;
                    end else if (confirmed && !force_flag) begin
                        if (cand_face != face_select) begin
                            pending_face <= cand_face;
                        end else begin
                            // Classifier settled back on the shown face: drop the switch.
                            state <= ST_RUN;
                        end
                    end
                end

                default: state <= ST_PRIME;
            endcase
        end
    end

    assign pixel_reset = (state == ST_PRIME);
    assign pending     = (state == ST_ARMED);
    assign seq_state   = state;

endmodule

// File: tb/tb_face_frame_sequencer.sv
module tb_face_frame_sequencer;

  localparam int DEFAULT_FACE    = 1;
  localparam int CONFIRM_COUNT   = 4;
  localparam int MIN_HOLD_FRAMES = 2;
  localparam int PRIME_CYCLES    = 2;
  localparam int NFACES          = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_face;
  logic        force_valid;
  logic [1:0]  force_face;
  logic [1:0]  face_select;
  logic        pixel_reset;
  logic        pending;
  logic [15:0] frame_count;
  logic [7:0]  switch_count;
  logic [1:0]  seq_state;

  face_frame_sequencer_if st_if ();

  face_frame_sequencer #(
    .DEFAULT_FACE    (DEFAULT_FACE),
    .CONFIRM_COUNT   (CONFIRM_COUNT),
    .MIN_HOLD_FRAMES (MIN_HOLD_FRAMES),
    .PRIME_CYCLES    (PRIME_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_face     (req_face),
    .force_valid  (force_valid),
    .force_face   (force_face),
    .st           (st_if),
    .face_select  (face_select),
    .pixel_reset  (pixel_reset),
    .pending      (pending),
    .frame_count  (frame_count),
    .switch_count (switch_count),
    .seq_state    (seq_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the observable story: which face is shown, which one is queued,
  // how many frames the shown face has been up, and the classifier streak.
  int m_face, m_pend, m_prime_left, m_hold, m_cand, m_streak, m_frames, m_switches;
  bit m_armed, m_forced;
  bit e_now, conf_old, frc;
  int hold_old, cand_old;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_face = DEFAULT_FACE; m_pend = DEFAULT_FACE; m_armed = 0; m_forced = 0;
      m_prime_left = PRIME_CYCLES; m_hold = MIN_HOLD_FRAMES;
      m_cand = DEFAULT_FACE; m_streak = 0; m_frames = 0; m_switches = 0;
    end else begin
      e_now    = st_if.st_valid && st_if.st_ready && st_if.st_eop;
      conf_old = (m_streak == CONFIRM_COUNT);
      hold_old = m_hold;
      cand_old = m_cand;
      frc      = force_valid && int'(force_face) < NFACES && int'(force_face) != m_face;
      if (req_valid && int'(req_face) < NFACES) begin
        if (int'(req_face) == m_cand) m_streak = (m_streak < CONFIRM_COUNT) ? m_streak + 1 : m_streak;
        else begin m_cand = int'(req_face); m_streak = 1; end
      end
      if (m_prime_left > 0) begin
        m_prime_left--;
      end else begin
        if (e_now) begin
          m_frames = (m_frames + 1) % 65536;
          if (m_hold < MIN_HOLD_FRAMES) m_hold++;
        end
        if (m_armed) begin
          if (e_now) begin
            m_face = m_pend; m_hold = 0; m_switches = (m_switches + 1) % 256;
            m_forced = 0; m_armed = 0;
          end else if (frc) begin
            m_pend = int'(force_face); m_forced = 1;
          end else if (conf_old && !m_forced) begin
            if (cand_old != m_face) m_pend = cand_old;
            else m_armed = 0;
          end
        end else begin
          if (frc) begin
            m_pend = int'(force_face); m_forced = 1; m_armed = 1;
          end else if (conf_old && cand_old != m_face && hold_old == MIN_HOLD_FRAMES) begin
            m_pend = cand_old; m_armed = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_face_select", int'(face_select), m_face);
      chk("cyc_pixel_reset", int'(pixel_reset), int'(m_prime_left > 0));
      chk("cyc_pending", int'(pending), int'(m_armed));
      chk("cyc_frame_count", int'(frame_count), m_frames);
      chk("cyc_switch_count", int'(switch_count), m_switches);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    force_valid = 1'b0;
    st_if.st_valid = 1'b0;
    st_if.st_ready = 1'b0;
    st_if.st_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_req(input int f);
    req_valid = 1'b1; req_face = 2'(f);
    tick();
  endtask

  task automatic send_eof();
    st_if.st_valid = 1'b1; st_if.st_ready = 1'b1; st_if.st_eop = 1'b1;
    tick();
  endtask

  task automatic send_force(input int f);
    force_valid = 1'b1; force_face = 2'(f);
    tick();
  endtask

  task automatic send_eof_force(input int f);
    force_valid = 1'b1; force_face = 2'(f);
    st_if.st_valid = 1'b1; st_if.st_ready = 1'b1; st_if.st_eop = 1'b1;
    tick();
  endtask

  task automatic send_beat(input bit v, input bit r, input bit e);
    st_if.st_valid = v; st_if.st_ready = r; st_if.st_eop = e;
    tick();
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_face = 2'd0;
    force_valid = 1'b0; force_face = 2'd0;
    st_if.st_valid = 1'b0; st_if.st_ready = 1'b0; st_if.st_eop = 1'b0;
    tick();
    chk_on = 1'b1;
    idle(2);
    chk("rst_pixel_reset", int'(pixel_reset), 1);
    chk("rst_face_select", int'(face_select), 1);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_switch_count", int'(switch_count), 0);
    chk("rst_pending", int'(pending), 0);

    // Priming: two cycles of pixel_reset after release.
    reset_n = 1'b1;
    tick();
    chk("prime_cycle1", int'(pixel_reset), 1);
    tick();
    chk("prime_done", int'(pixel_reset), 0);

    // Invalid force code and force to the shown face do nothing.
    send_force(3);
    send_force(1);
    chk("force_noop_pending", int'(pending), 0);

    // Broken streak: 2,2,0,2,2,2 never reaches 4; handshakes without eof.
    send_req(2); send_req(2); send_req(0);
    send_req(2); send_req(2); send_req(2);
    send_beat(1, 0, 1);
    send_beat(1, 1, 0);
    idle(2);
    chk("streak_no_pending", int'(pending), 0);
    send_eof(); send_eof();
    idle(1);
    chk("streak_face_kept", int'(face_select), 1);
    chk("streak_frames", int'(frame_count), 2);

    // Clean confirm of 2 then commit on eof.
    send_req(1);
    send_req(2); send_req(2); send_req(2); send_req(2);
    chk("confirm_not_yet", int'(pending), 0);
    tick();
    chk("confirm_pending", int'(pending), 1);
    chk("confirm_face_pre_eof", int'(face_select), 1);
    send_eof();
    chk("commit_face", int'(face_select), 2);
    chk("commit_switches", int'(switch_count), 1);
    chk("commit_frames", int'(frame_count), 3);

    // Hold gate: confirmed 0 waits for two completed frames.
    send_req(0); send_req(0); send_req(0); send_req(0);
    idle(2);
    chk("hold0_pending", int'(pending), 0);
    send_eof();
    idle(1);
    chk("hold1_pending", int'(pending), 0);
    send_eof();
    chk("hold2_edge_pending", int'(pending), 0);
    tick();
    chk("hold_armed", int'(pending), 1);
    send_eof();
    chk("hold_commit_face", int'(face_select), 0);
    chk("hold_commit_switches", int'(switch_count), 2);

    // Force bypasses the hold gate.
    send_force(1);
    chk("force_armed", int'(pending), 1);
    send_eof();
    chk("force_commit_face", int'(face_select), 1);

    // Armed for 0, then forced to 2; a later confirmed 1 must not overwrite.
    send_eof(); send_eof();
    tick();
    chk("armed_for0", int'(pending), 1);
    send_force(2);
    send_req(1); send_req(1); send_req(1); send_req(1);
    idle(2);
    send_eof();
    chk("force_sticky_face", int'(face_select), 2);
    chk("force_sticky_switches", int'(switch_count), 4);

    // Cancel: armed for 1, classifier returns to the shown face 2.
    send_eof(); send_eof();
    tick();
    chk("armed_for1", int'(pending), 1);
    send_req(2); send_req(2); send_req(2); send_req(2);
    tick();
    chk("cancel_pending", int'(pending), 0);
    send_eof();
    chk("cancel_face", int'(face_select), 2);
    chk("cancel_frames", int'(frame_count), 13);

    // eof and force together: commit uses the already armed face.
    send_force(0);
    send_eof_force(1);
    chk("simul_face", int'(face_select), 0);
    chk("simul_switches", int'(switch_count), 5);
    tick();
    chk("simul_after_pending", int'(pending), 0);

    // Force and confirmation together: force wins.
    send_eof(); send_eof();
    send_force(1);
    tick();
    send_eof();
    chk("force_wins_face", int'(face_select), 1);
    chk("force_wins_frames", int'(frame_count), 17);

    // Out-of-range classifier codes are ignored.
    send_req(0);
    repeat (10) send_req(3);
    send_eof(); send_eof();
    idle(2);
    chk("code3_no_confirm", int'(pending), 0);
    send_req(0); send_req(0); send_req(0);
    tick();
    chk("code3_then_confirm", int'(pending), 1);

    // Mid-frame reset.
    st_if.st_valid = 1'b1; st_if.st_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    chk("midrst_pixel_reset", int'(pixel_reset), 1);
    chk("midrst_face", int'(face_select), 1);
    chk("midrst_frames", int'(frame_count), 0);
    chk("midrst_switches", int'(switch_count), 0);
    chk("midrst_pending", int'(pending), 0);
    reset_n = 1'b1;
    tick();
    chk("reprime_cycle1", int'(pixel_reset), 1);
    tick();
    chk("reprime_done", int'(pixel_reset), 0);
    send_req(2); send_req(2); send_req(2); send_req(2);
    tick();
    send_eof();
    chk("post_rst_face", int'(face_select), 2);
    chk("post_rst_switches", int'(switch_count), 1);
    chk("post_rst_frames", int'(frame_count), 1);

    idle(2);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
